mod3_serial_checker: RTL
========================

Name: mod3_serial_checker

Overview:
- Downstream consumer of the 5-bit synchronous counter (count range 0..30, wraps to 0).
- Samples one count value per handshake and classifies it serially, MSB-first, with a 3-state remainder FSM.
- Reports the remainder mod 3 and a multiple-of-three flag over a valid/ready output handshake.
- Feeds a pattern/monitor stage that checks the counter's multiples-of-three sequence.

Parameters:
- WIDTH, 5, bit width of the input value and shift register; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the clk rising edge.
- in_valid  input  1  upstream has a value on in_data.
- in_ready  output  1  block can accept a value (high only in IDLE).
- in_data  input  WIDTH  value to classify (the counter's Q).
- out_valid  output  1  result is available; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  copy of the accepted input value.
- out_rem  output  2  in_data mod 3 (0, 1 or 2; 3 never appears).
- out_is_mult3  output  1  1 when out_rem == 0.

Behaviour:
- Reset: state = IDLE; shift register, bit counter, remainder, out_data, out_rem and out_is_mult3 = 0; out_valid = 0; in_ready = 1 in the cycle after reset.
- Reset has priority over every other event, including reset asserted mid-SHIFT or in DONE. The in-flight value is dropped and no out_valid pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - When in_valid is high at a clock edge, the block captures in_data into the shift register and out_data, sets remainder = 0 and bit counter = WIDTH, then moves to SHIFT.
- SHIFT:
  - in_ready = 0. Each edge consumes the shift register MSB b: rem_next = (2*rem + b) mod 3, then the register shifts left by 1 and the counter decrements.
  - Remainder table (rem,b -> rem_next): 0,0->0; 0,1->1; 1,0->2; 1,1->0; 2,0->1; 2,1->2.
  - On the edge where counter == 1 (the last bit), the block goes to DONE and registers out_rem and out_is_mult3 from rem_next.
- DONE:
  - out_valid = 1, in_ready = 0. out_data, out_rem and out_is_mult3 hold stable.
  - On an edge with out_ready = 1: go to IDLE; out_valid drops the next cycle.
- Latency: the handshake at edge T gives out_valid high from the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles (6 at the default).
- Minimum spacing between acceptances is WIDTH+2 cycles. There is no DONE->SHIFT bypass.
- in_valid in SHIFT or DONE is ignored. Upstream holds or re-presents; a free-running counter is simply sampled.
- out_ready while out_valid = 0 has no effect.
- Remainder registers are 2 bits; the state encoding 3 is unreachable and is forced to 0 if ever reached.
- All outputs are registered or decoded from the state only. There are no combinational paths from input to output.

Optional Feature:
- Macro: MOD3_HIT_COUNT_EN.
- With the macro defined:
  - Adds output port hit_count, 8 bits, reset to 0.
  - Increments by 1 on each completed output handshake (out_valid & out_ready) with out_is_mult3 = 1.
  - Saturates at 255 and does not wrap.
  - Cleared only by reset.
- Without the macro: the port and its counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles -> in_ready=1, out_valid=0, out_rem=0, out_is_mult3=0, out_data=0.
- in_data=30 (11110) accepted at edge T, out_ready=1 -> out_valid high in the cycle after T+5, out_rem=0, out_is_mult3=1, out_data=30. Repeat for 29 -> rem 2, mult3 0; 0 -> rem 0, mult3 1; 31 -> rem 1, mult3 0.
- Back-pressure: result for 27 with out_ready=0 for 10 cycles -> out_valid stays 1, outputs stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE the next cycle.
- Reset asserted 3 cycles into SHIFT with in_data=21 -> IDLE the next cycle, no out_valid at any point, in_ready=1.
- Sweep 0..30 (counter-style source, one value per acceptance, out_ready=1) -> out_is_mult3=1 exactly for 0,3,6,...,30 (11 values). out_rem matches value mod 3 for all 31 values.
- MOD3_HIT_COUNT_EN defined: the sweep above gives hit_count=11. 300 accepted multiples give hit_count=255 (saturated). Reset -> 0.

Source files
------------

// File: rtl/mod3_serial_checker_if.sv
// Handshake bundle for mod3_serial_checker: value in, classified result out.
interface mod3_serial_checker_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_rem;
    logic             out_is_mult3;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_rem, out_is_mult3
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_rem, out_is_mult3
    );
endinterface

// File: rtl/mod3_serial_checker.sv
// Serial MSB-first mod-3 classifier for counter samples.
// Optional MOD3_HIT_COUNT_EN adds a saturating 8-bit count of accepted multiples of three.
//
// state | meaning
// IDLE  | waiting for a value, in_ready high
// SHIFT | consuming one bit per cycle into the remainder
// DONE  | result presented, out_valid high until accepted
module mod3_serial_checker #(
    parameter int WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    mod3_serial_checker_if.slave          bus
`ifdef MOD3_HIT_COUNT_EN
    ,
    output logic [7:0]                    hit_count
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       rem_q;
    logic [1:0]       rem_next;
    logic [1:0]       out_rem_q;
    logic             mult3_q;
    logic             last_bit;

    // Remainder encoding 3 is unreachable; any such value collapses to 0.
    function automatic logic [1:0] rem_step(input logic [1:0] rem, input logic b);
        case ({rem, b})
            3'b000:  rem_step = 2'd0;
            3'b001:  rem_step = 2'd1;
            3'b010:  rem_step = 2'd2;
            3'b011:  rem_step = 2'd0;
            3'b100:  rem_step = 2'd1;
            3'b101:  rem_step = 2'd2;
            default: rem_step = 2'd0;
        endcase
    endfunction

    assign rem_next = rem_step(rem_q, shift_q[WIDTH-1]);
    assign last_bit = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            rem_q     <= 2'd0;
            out_rem_q <= 2'd0;
            mult3_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_q <= bus.in_data;
                        data_q  <= bus.in_data;
                        rem_q   <= 2'd0;
                        cnt_q   <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    rem_q   <= rem_next;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (last_bit) begin
                        out_rem_q <= rem_next;
                        mult3_q   <= (rem_next == 2'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data     = data_q;
    assign bus.out_rem      = out_rem_q;
    assign bus.out_is_mult3 = mult3_q;

`ifdef MOD3_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            hit_count <= 8'd0;
        else if (bus.out_valid && bus.out_ready && mult3_q && (hit_count != 8'hFF))
            hit_count <= hit_count + 8'd1;
    end
`endif
endmodule
